scene_matrix_memory: RTL and testbench
======================================

// Module: scene_matrix_memory
// PURPOSE
//  Occupancy store for the playfield; responder side of the matrix-memory port driven by current_tile_memory.
//  Returns a 4x4 occupancy window at the requested point (walls/floor read as occupied).
//  Locks a landed tile into the field, then runs a row-scan FSM that removes full lines and shifts rows above down.
//  Also provides a per-row readout for the display path.
// PARAMETERS
//  scene_width_p   10  playfield columns (x); x_m width of point_t must cover scene_width_p+3
//  scene_height_p  20  playfield rows (y); row 0 = top, row scene_height_p-1 = bottom
// PORTS
//  clk_i            in   1        clock
//  reset_i          in   1        synchronous, active-high reset
//  mm_addr_i        in   point_t  window origin (x_m, y_m)
//  mm_data_o        out  [3:0][3:0] window; [i][j] = cell(x_m+j, y_m+i)
//  commit_v_i       in   1        lock request (accepted only when ready_o)
//  commit_pos_i     in   point_t  origin of shape to lock
//  commit_shape_i   in   shape_t  4x4 shape, same [i][j] indexing as mm_data_o
//  clear_i          in   1        wipe entire field (new game)
//  row_addr_i       in   $clog2(scene_height_p)  display row select
//  row_data_o       out  scene_width_p  occupancy of row_addr_i, bit k = column k
//  ready_o          out  1        FSM idle; commit accepted
//  done_o           out  1        one-cycle pulse: commit + line clearing finished
//  lines_cleared_o  out  3        lines removed by last commit (0..4), held until next done_o
//  top_blocked_o    out  1        any cell in row 0 occupied
// BEHAVIOUR
//  - Reset: field all 0, state eIDLE, ready_o=1, done_o=0, lines_cleared_o=0, top_blocked_o=0.
//  - Read path combinational, valid in every state: cell with x>=scene_width_p or y>=scene_height_p reads 1; else stored bit.
//  - row_data_o combinational; row_addr_i>=scene_height_p returns all 0.
//  - States: eIDLE, eScan. ready_o = (state==eIDLE).
//  - eIDLE & commit_v_i & ~clear_i: at that edge field |= shape placed at commit_pos_i (out-of-range bits dropped),
//    row_idx <= scene_height_p-1, count <= 0, state <= eScan.
//  - eScan, each cycle checks row_idx:
//    full row: rows[row_idx..1] <= rows[row_idx-1..0], row 0 <= 0, count++, row_idx unchanged (recheck).
//    not full, row_idx!=0: row_idx--.  not full, row_idx==0: state <= eIDLE, lines_cleared_o <= count, done_o <= 1.
//  - done_o is high exactly in the first eIDLE cycle after eScan; 0 otherwise.
//  - Latency: commit accepted at edge T -> ready_o high at T + scene_height_p + (lines cleared) cycles.
//  - commit_v_i while ready_o=0: ignored, no effect, no queuing.
//  - clear_i (any state, priority over commit): next edge field=0, state=eIDLE, no done_o pulse, lines_cleared_o unchanged.
//  - reset_i mid-scan: identical to reset; partial shift discarded.
//  - count saturates at 4 (cannot exceed with 4-row shapes; saturation is a guard only).
// CONFIGURATION
//  SCENE_MM_LINE_TOTAL_EN defined: adds output total_lines_o [15:0]; += lines_cleared on each done_o;
//    cleared to 0 by reset_i or clear_i; saturates at 16'hFFFF.
//  Not defined: port absent, no counter logic.
// TESTING (scene_width_p=10, scene_height_p=20)
//  1. Reset, mm_addr_i=(0,0) -> mm_data_o=0; mm_addr_i=(8,0) -> columns j=2,3 all 1, j=0,1 all 0.
//  2. mm_addr_i=(0,18) -> rows i=2,3 all 1, rows i=0,1 0; row_addr_i=25 -> row_data_o=0.
//  3. Commit shape row3=4'hF at (0,16),(4,16) -> each ready_o low 20 cycles, done_o pulse, lines_cleared_o=0, row_data_o[19]=0x0FF.
//  4. Then commit row3=4'h3<<? covering x 8..9 at (8,16) with shape[3]=4'b0011 -> row 19 cleared, ready_o low 21 cycles,
//     lines_cleared_o=1, row_data_o[19]=0, total_lines_o=1 (macro on).
//  5. clear_i asserted 5 cycles into eScan -> next cycle ready_o=1, field 0, no done_o pulse.
//  6. commit_v_i held high during eScan -> no second merge; one done_o per accepted commit.

Source files
------------

// File: rtl/scene_matrix_memory.sv
// Playfield occupancy store: 4x4 window reads, tile locking, line-clear row scan, row readout.
// Optional SCENE_MM_LINE_TOTAL_EN adds a saturating total_lines_o counter.
package scene_matrix_memory_pkg;
   typedef struct packed {
      logic [4:0] x_m;
      logic [4:0] y_m;
   } point_t;
   typedef logic [3:0][3:0] shape_t;
endpackage

module scene_matrix_memory
   import scene_matrix_memory_pkg::*;
#(
   parameter int scene_width_p  = 10,
   parameter int scene_height_p = 20
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  point_t                            mm_addr_i,
   output shape_t                            mm_data_o,
   input  logic                              commit_v_i,
   input  point_t                            commit_pos_i,
   input  shape_t                            commit_shape_i,
   input  logic                              clear_i,
   input  logic [$clog2(scene_height_p)-1:0] row_addr_i,
   output logic [scene_width_p-1:0]          row_data_o,
   output logic                              ready_o,
   output logic                              done_o,
   output logic [2:0]                        lines_cleared_o,
   output logic                              top_blocked_o
`ifdef SCENE_MM_LINE_TOTAL_EN
   ,
   output logic [15:0]                       total_lines_o
`endif
);

   localparam int xw = $clog2(scene_width_p);
   localparam int yw = $clog2(scene_height_p);

   typedef enum logic {eIDLE, eScan} state_e;

   state_e                   state;
   logic [scene_width_p-1:0] rows   [scene_height_p];
   logic [scene_width_p-1:0] merged [scene_height_p];
   logic [yw-1:0]            row_idx;
   logic [2:0]               count;
   logic                     row_full;

   // Anything outside the field (walls to the right, floor below) reads as occupied.
   always_comb begin
      int cx, cy;
      // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
      mm_data_o = '0;
      cx = 0;
      cy = 0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            cx = int'(mm_addr_i.x_m) + j;
            cy = int'(mm_addr_i.y_m) + i;
            if (cx >= scene_width_p || cy >= scene_height_p)
               mm_data_o[i][j] = 1'b1;
            else
               mm_data_o[i][j] = rows[cy[yw-1:0]][cx[xw-1:0]];
         end
      end
   end

   always_comb begin
      row_data_o = '0;
      if (int'(row_addr_i) < scene_height_p)
         row_data_o = rows[row_addr_i];
   end

   // Field with the committed shape OR-ed in; shape bits landing off-field are dropped.
   always_comb begin
      int cx, cy;
      cx = 0;
      cy = 0;
      for (int r = 0; r < scene_height_p; r++)
         merged[r] = rows[r];
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            cx = int'(commit_pos_i.x_m) + j;
            cy = int'(commit_pos_i.y_m) + i;
            if (commit_shape_i[i][j] && cx < scene_width_p && cy < scene_height_p)
               merged[cy[yw-1:0]][cx[xw-1:0]] = 1'b1;
         end
      end
   end

   assign row_full      = (rows[row_idx] == '1);
   assign ready_o       = (state == eIDLE);
   assign top_blocked_o = |rows[0];

`ifdef SCENE_MM_LINE_TOTAL_EN
   logic [16:0] total_sum;
   assign total_sum = {1'b0, total_lines_o} + 17'(count);
`endif

   // NOTE: the field lives in flops, not RAM: the window needs all rows in parallel and reset must zero it.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         // NOTE: sequential state uses non-blocking assignments only.
         state           <= eIDLE;
         row_idx         <= '0;
         count           <= '0;
         done_o          <= 1'b0;
         lines_cleared_o <= '0;
         for (int r = 0; r < scene_height_p; r++)
            rows[r] <= '0;
`ifdef SCENE_MM_LINE_TOTAL_EN
         total_lines_o <= '0;
`endif
      end else if (clear_i) begin
         state  <= eIDLE;
         done_o <= 1'b0;
         for (int r = 0; r < scene_height_p; r++)
            rows[r] <= '0;
`ifdef SCENE_MM_LINE_TOTAL_EN
         total_lines_o <= '0;
`endif
      end else begin
         done_o <= 1'b0;
         case (state)
            eIDLE: begin
               if (commit_v_i) begin
                  for (int r = 0; r < scene_height_p; r++)
                     rows[r] <= merged[r];
                  row_idx <= yw'(scene_height_p - 1);
                  count   <= '0;
                  state   <= eScan;
               end
            end
            eScan: begin
               if (row_full) begin
                  // Drop everything above the full row by one; recheck the same index next cycle.
                  for (int r = 1; r < scene_height_p; r++)
                     if (yw'(r) <= row_idx)
                        rows[r] <= rows[r-1];
                  rows[0] <= '0;
                  if (count != 3'd4)
                     count <= count + 3'd1;
               end else if (row_idx != '0) begin
                  row_idx <= row_idx - 1'b1;
               end else begin
                  state           <= eIDLE;
                  lines_cleared_o <= count;
                  done_o          <= 1'b1;
`ifdef SCENE_MM_LINE_TOTAL_EN
                  total_lines_o <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
`endif
               end
            end
            default: state <= eIDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_scene_matrix_memory.sv
// Self-checking bench for scene_matrix_memory: reference-window table, commit scoreboard, scan corner cases.
module tb_scene_matrix_memory;
   import scene_matrix_memory_pkg::*;

   localparam int W = 10;
   localparam int H = 20;

   logic         clk_i = 1'b0;
   logic         reset_i;
   point_t       mm_addr_i;
   shape_t       mm_data_o;
   logic         commit_v_i;
   point_t       commit_pos_i;
   shape_t       commit_shape_i;
   logic         clear_i;
   logic [4:0]   row_addr_i;
   logic [W-1:0] row_data_o;
   logic         ready_o;
   logic         done_o;
   logic [2:0]   lines_cleared_o;
   logic         top_blocked_o;
`ifdef SCENE_MM_LINE_TOTAL_EN
   logic [15:0]  total_lines_o;
`endif

   scene_matrix_memory #(.scene_width_p(W), .scene_height_p(H)) dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .mm_addr_i       (mm_addr_i),
      .mm_data_o       (mm_data_o),
      .commit_v_i      (commit_v_i),
      .commit_pos_i    (commit_pos_i),
      .commit_shape_i  (commit_shape_i),
      .clear_i         (clear_i),
      .row_addr_i      (row_addr_i),
      .row_data_o      (row_data_o),
      .ready_o         (ready_o),
      .done_o          (done_o),
      .lines_cleared_o (lines_cleared_o),
      .top_blocked_o   (top_blocked_o)
`ifdef SCENE_MM_LINE_TOTAL_EN
      ,
      .total_lines_o   (total_lines_o)
`endif
   );

   always #50 clk_i = ~clk_i;

   int tests_run = 0;
   int tests_failed = 0;
   int done_seen = 0;
   int commits_accepted = 0;
   int total_expected = 0;
   int last_lines = 0;
   int exp_q[$];
   logic [W-1:0] model [H];

   typedef struct {
      point_t     addr;
      logic [4:0] row;
      logic [15:0] win;
      logic [W-1:0] rdata;
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input int actual, input int expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic point_t mkp(input int x, input int y);
      point_t p;
      p.x_m = 5'(x);
      p.y_m = 5'(y);
      return p;
   endfunction

   function automatic shape_t rshape(input int i, input logic [3:0] bits);
      shape_t s = '0;
      s[i] = bits;
      return s;
   endfunction

   function automatic void model_clear();
      for (int r = 0; r < H; r++) model[r] = '0;
   endfunction

   // Merge, then compact the surviving rows toward the floor in one pass.
   function automatic int model_commit(input point_t p, input shape_t s);
      logic [W-1:0] tmp [H];
      int n = 0;
      int w = H - 1;
      int cx, cy;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            cx = int'(p.x_m) + j;
            cy = int'(p.y_m) + i;
            if (s[i][j] && cx < W && cy < H) model[cy[4:0]][cx[3:0]] = 1'b1;
         end
      for (int r = 0; r < H; r++) tmp[r] = '0;
      for (int r = H - 1; r >= 0; r--) begin
         if (model[r] == '1) n++;
         else begin
            tmp[w[4:0]] = model[r];
            w--;
         end
      end
      for (int r = 0; r < H; r++) model[r] = tmp[r];
      return n;
   endfunction

   function automatic logic [15:0] model_window(input int x, input int y);
      logic [15:0] v = '0;
      int cx, cy;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            cx = x + j;
            cy = y + i;
            v[i*4+j] = (cx >= W || cy >= H) ? 1'b1 : model[cy[4:0]][cx[3:0]];
         end
      return v;
   endfunction

   task automatic check_rows(input string tag);
      for (int r = 0; r < H; r++) begin
         row_addr_i = 5'(r);
         #1;
         check($sformatf("%s_row%0d", tag, r), int'(row_data_o), int'(model[r]));
      end
      check({tag, "_top_blocked"}, int'(top_blocked_o), int'(|model[0]));
   endtask

   task automatic check_window(input int x, input int y);
      mm_addr_i = mkp(x, y);
      #1;
      check($sformatf("win_%0d_%0d", x, y), int'(mm_data_o), int'(model_window(x, y)));
   endtask

   task automatic commit_and_wait(input string name, input point_t p, input shape_t s);
      int n = 0;
      int lines;
      while (!ready_o && n < 60) begin tick(); n++; end
      commit_pos_i   = p;
      commit_shape_i = s;
      commit_v_i     = 1'b1;
      lines = model_commit(p, s);
      exp_q.push_back(lines);
      commits_accepted++;
      total_expected += lines;
      tick();
      commit_v_i = 1'b0;
      check({name, "_busy"}, int'(ready_o), 0);
      n = 0;
      while (!ready_o && n < 60) begin tick(); n++; end
      check({name, "_latency"}, n, H + lines);
      check({name, "_done"}, int'(done_o), 1);
      last_lines = lines;
      tick();
      check({name, "_done_drop"}, int'(done_o), 0);
      check_rows(name);
   endtask

   // Scoreboard side: every done_o pulse must match the oldest accepted commit.
   always @(negedge clk_i) begin
      if (done_o) begin
         done_seen++;
         if (exp_q.size() == 0)
            check("done_without_commit", int'(done_o), 0);
         else
            check("lines_cleared", int'(lines_cleared_o), exp_q.pop_front());
      end
   end

   initial begin
      int n;
      int saved_done;
      vecs[0] = '{mkp(0, 0),  5'd0,  16'h0000, 10'h000};
      vecs[1] = '{mkp(8, 0),  5'd19, 16'hCCCC, 10'h000};
      vecs[2] = '{mkp(0, 18), 5'd25, 16'hFF00, 10'h000};
      vecs[3] = '{mkp(9, 19), 5'd31, 16'hFFFE, 10'h000};
      vecs[4] = '{mkp(12, 3), 5'd5,  16'hFFFF, 10'h000};
      vecs[5] = '{mkp(6, 17), 5'd20, 16'hF000, 10'h000};

      reset_i = 1'b1; commit_v_i = 1'b0; clear_i = 1'b0;
      commit_pos_i = mkp(0, 0); commit_shape_i = '0;
      mm_addr_i = mkp(0, 0); row_addr_i = '0;
      model_clear();
      tick(); tick();
      reset_i = 1'b0;
      #1;
      check("rst_ready", int'(ready_o), 1);
      check("rst_done", int'(done_o), 0);
      check("rst_lines", int'(lines_cleared_o), 0);
      check("rst_top", int'(top_blocked_o), 0);
`ifdef SCENE_MM_LINE_TOTAL_EN
      check("rst_total", int'(total_lines_o), 0);
`endif

      foreach (vecs[k]) begin
         mm_addr_i  = vecs[k].addr;
         row_addr_i = vecs[k].row;
         #1;
         check($sformatf("vec%0d_win", k), int'(mm_data_o), int'(vecs[k].win));
         check($sformatf("vec%0d_row", k), int'(row_data_o), int'(vecs[k].rdata));
      end

      commit_and_wait("c_left", mkp(0, 16), rshape(3, 4'hF));
      commit_and_wait("c_mid", mkp(4, 16), rshape(3, 4'hF));
      row_addr_i = 5'd19;
      #1;
      check("row19_0ff", int'(row_data_o), 10'h0FF);
      commit_and_wait("c_line1", mkp(8, 16), rshape(3, 4'b0011));
      check("line1_count", int'(lines_cleared_o), 1);
`ifdef SCENE_MM_LINE_TOTAL_EN
      check("line1_total", int'(total_lines_o), 1);
`endif
      commit_and_wait("c_edge", mkp(8, 10), rshape(3, 4'hF));
      commit_and_wait("c_single", mkp(0, 14), rshape(3, 4'h1));
      commit_and_wait("c_pairl", mkp(0, 16), rshape(2, 4'hF) | rshape(3, 4'hF));
      commit_and_wait("c_pairm", mkp(4, 16), rshape(2, 4'hF) | rshape(3, 4'hF));
      commit_and_wait("c_line2", mkp(8, 16), rshape(2, 4'b0011) | rshape(3, 4'b0011));
      check("line2_count", int'(lines_cleared_o), 2);
`ifdef SCENE_MM_LINE_TOTAL_EN
      check("line2_total", int'(total_lines_o), total_expected);
`endif
      check_window(0, 16);
      check_window(6, 16);
      check_window(8, 12);
      check_window(7, 18);

      // Clear five cycles into a scan: no done pulse, lines_cleared_o keeps its value.
      saved_done = done_seen;
      commit_pos_i = mkp(0, 10); commit_shape_i = rshape(0, 4'hF); commit_v_i = 1'b1;
      tick();
      commit_v_i = 1'b0;
      check("clr_busy", int'(ready_o), 0);
      repeat (5) tick();
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      model_clear();
      check("clr_ready", int'(ready_o), 1);
      check("clr_done", int'(done_o), 0);
      check("clr_lines_kept", int'(lines_cleared_o), last_lines);
`ifdef SCENE_MM_LINE_TOTAL_EN
      check("clr_total", int'(total_lines_o), 0);
      total_expected = 0;
`endif
      check_rows("clr");
      repeat (25) tick();
      check("clr_no_done", done_seen, saved_done);

      // Commit held high through the scan, with the target moved: only the first merge lands.
      commit_pos_i = mkp(0, 0); commit_shape_i = rshape(0, 4'h1); commit_v_i = 1'b1;
      exp_q.push_back(model_commit(mkp(0, 0), rshape(0, 4'h1)));
      commits_accepted++;
      tick();
      commit_pos_i = mkp(5, 5);
      n = 0;
      while (!ready_o && n < 60) begin tick(); n++; end
      commit_v_i = 1'b0;
      check("held_latency", n, H);
      tick();
      check_rows("held");

      // Commit and clear together: clear wins.
      commit_pos_i = mkp(0, 19); commit_shape_i = rshape(0, 4'hF);
      commit_v_i = 1'b1; clear_i = 1'b1;
      tick();
      commit_v_i = 1'b0; clear_i = 1'b0;
      model_clear();
      check("cc_ready", int'(ready_o), 1);
      check_rows("cc");

      // Reset mid-scan discards the partial work.
      saved_done = done_seen;
      commit_pos_i = mkp(0, 12); commit_shape_i = rshape(0, 4'hF); commit_v_i = 1'b1;
      tick();
      commit_v_i = 1'b0;
      repeat (3) tick();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      check("rstm_ready", int'(ready_o), 1);
      check("rstm_lines", int'(lines_cleared_o), 0);
      check_rows("rstm");
      repeat (25) tick();
      check("rstm_no_done", done_seen, saved_done);

      check("scoreboard_drained", exp_q.size(), 0);
      check("done_count", done_seen, commits_accepted);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
